// File: rtl/xres_conditioner_pkg.sv
// Shared definitions for the multi-channel xres reset conditioner:
// sequencer state encodings, parameter floors and small elaboration helpers.
package xres_conditioner_pkg;

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_STRETCH = 3'd1,
        ST_RELEASE = 3'd2,
        ST_GAP     = 3'd3,
        ST_RUN     = 3'd4
    } xres_state_e;

    // Floors applied to the tuning parameters so a bad override cannot
    // produce a zero-depth synchroniser or a zero-length count.
    localparam int XRES_MIN_SYNC  = 2;
    localparam int XRES_MIN_COUNT = 1;

    function automatic int xres_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/xres_conditioner_filter.sv
// One channel of request conditioning: a synchroniser on the deasserting
// edge of xres followed by a consecutive-high filter. The whole channel is
// cleared asynchronously by its own request, so req_ok_o drops with no clock.
// req_ok_o is high during the cycle whose closing edge is the FILTER_CYCLES-th
// consecutive synced-high sample, so the sequencer acts on that same edge.
module xres_conditioner_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic xres_i,
    output logic req_ok_o
);

    localparam int            FW        = $clog2(FILTER_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FW-1:0]          filt_q;
    logic [FW-1:0]          filt_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Synchroniser chain for the asynchronous pad request
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], xres_i};
        end
    end

    // Count consecutive synced-high cycles, saturating at the last step
    always_comb begin
        filt_d = filt_q;
        if (!synced) begin
            filt_d = '0;
        end else if (filt_q != FILT_LAST) begin
            filt_d = filt_q + 1'b1;
        end
    end

    // Filter count register
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            filt_q <= '0;
        end else begin
            filt_q <= filt_d;
        end
    end

    assign req_ok_o = synced && (filt_q == FILT_LAST);

endmodule

// File: rtl/xres_conditioner.sv
// Multi-channel xres reset conditioner. Each channel's output asserts
// asynchronously with its raw request; release is synchronised, filtered,
// stretched and then sequenced from channel 0 upwards by a pointer FSM.
// Any lower channel re-entering reset pulls every higher channel back down.
module xres_conditioner
    import xres_conditioner_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 4,
    parameter int STRETCH_CYCLES = 16,
    parameter int SEQ_GAP        = 8
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic [NUM_CH-1:0] xres_in,
    output logic [NUM_CH-1:0] resetb_out,
    output logic              rst_busy,
    output logic [NUM_CH-1:0] xres_seen,
    input  logic              seen_clr
);

    localparam int SYNC_N = xres_max(SYNC_STAGES, XRES_MIN_SYNC);
    localparam int FILT_N = xres_max(FILTER_CYCLES, XRES_MIN_COUNT);
    localparam int STR_N  = xres_max(STRETCH_CYCLES, XRES_MIN_COUNT);
    localparam int GAP_N  = xres_max(SEQ_GAP, XRES_MIN_COUNT);
    localparam int CNT_W  = $clog2(xres_max(STR_N, GAP_N) + 1);
    localparam int PTR_W  = $clog2(NUM_CH + 1);

    localparam logic [CNT_W-1:0] STR_LAST = CNT_W'(STR_N - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_N - 1);
    localparam logic [PTR_W-1:0] PTR_END  = PTR_W'(NUM_CH);

    xres_state_e       state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d, drop_idx;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q;
    logic [NUM_CH-1:0] seen_q, seen_d;
    logic [NUM_CH-1:0] out_q;
    logic [NUM_CH-1:0] arst_n;
    logic [NUM_CH-1:0] req_ok;
    logic              drop_found;
    logic              ok_at_ptr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic out_bit_q;

        assign arst_n[g] = resetb & xres_in[g];

        xres_conditioner_filter #(
            .SYNC_STAGES  (SYNC_N),
            .FILTER_CYCLES(FILT_N)
        ) u_filter (
            .clk_i   (clock),
            .arst_ni (arst_n[g]),
            .xres_i  (xres_in[g]),
            .req_ok_o(req_ok[g])
        );

        // Output flop: asserts with its own request, releases once the pointer passes it
        always_ff @(posedge clock or negedge arst_n[g]) begin
            if (!arst_n[g]) begin
                out_bit_q <= 1'b0;
            end else begin
                out_bit_q <= (PTR_W'(g) < ptr_d);
            end
        end

        assign out_q[g] = out_bit_q;
    end

    // Find the lowest released channel that lost its request, and the ok flag at ptr
    always_comb begin
        drop_found = 1'b0;
        drop_idx   = '0;
        ok_at_ptr  = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if ((PTR_W'(k) < ptr_q) && !req_ok[k]) begin
                drop_found = 1'b1;
                drop_idx   = PTR_W'(k);
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (ptr_q == PTR_W'(k)) begin
                ok_at_ptr = req_ok[k];
            end
        end
    end

    // Release sequencer next-state: re-assertion overrides every state
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (drop_found) begin
            state_d = ST_HOLD;
            ptr_d   = drop_idx;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (ok_at_ptr) begin
                        state_d = ST_STRETCH;
                        cnt_d   = '0;
                    end
                end
                ST_STRETCH: begin
                    if (!ok_at_ptr) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else if (cnt_q == STR_LAST) begin
                        state_d = ST_RELEASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                ST_RELEASE: begin
                    cnt_d = '0;
                    if (!ok_at_ptr) begin
                        state_d = ST_HOLD;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = (ptr_d == PTR_END) ? ST_RUN : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (!ok_at_ptr) begin
                        cnt_d = '0;
                    end else if (cnt_q == GAP_LAST) begin
                        state_d = ST_RELEASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_HOLD;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Sticky request record: setting wins over a same-cycle clear
    always_comb begin
        seen_d = (seen_clr ? '0 : seen_q) | ~req_ok;
    end

    // Sequencer, busy flag and sticky registers
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_HOLD;
            ptr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            seen_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != ST_RUN);
            seen_q  <= seen_d;
        end
    end

    assign resetb_out = out_q;
    assign rst_busy   = busy_q;
    assign xres_seen  = seen_q;

endmodule

// File: tb/tb_xres_conditioner.sv
// Directed bench for xres_conditioner: default 2-channel instance plus a
// 4-channel, SEQ_GAP=1 instance for the ordered-release sweep.
module tb_xres_conditioner;
    import xres_conditioner_pkg::*;

    logic       clock = 1'b0;
    logic       resetb;
    logic [1:0] xres_in;
    logic [1:0] resetb_out;
    logic       rst_busy;
    logic [1:0] xres_seen;
    logic       seen_clr;

    logic       resetb4;
    logic [3:0] xres4;
    logic [3:0] out4;
    logic       busy4;
    logic [3:0] seen4;
    logic       clr4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    xres_conditioner #(
        .NUM_CH(2), .SYNC_STAGES(2), .FILTER_CYCLES(4),
        .STRETCH_CYCLES(16), .SEQ_GAP(8)
    ) dut (
        .clock(clock), .resetb(resetb), .xres_in(xres_in),
        .resetb_out(resetb_out), .rst_busy(rst_busy),
        .xres_seen(xres_seen), .seen_clr(seen_clr)
    );

    xres_conditioner #(
        .NUM_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(4),
        .STRETCH_CYCLES(16), .SEQ_GAP(1)
    ) u4 (
        .clock(clock), .resetb(resetb4), .xres_in(xres4),
        .resetb_out(out4), .rst_busy(busy4),
        .xres_seen(seen4), .seen_clr(clr4)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [1:0] exp_out;
        resetb   = 1'b0;
        xres_in  = 2'b11;
        seen_clr = 1'b0;
        step();
        step();
        n_cmp++;
        if (resetb_out !== 2'b00) begin
            n_err++; $display("FAIL reset_out: got %b want 00", resetb_out);
        end
        n_cmp++;
        if (rst_busy !== 1'b1) begin
            n_err++; $display("FAIL reset_busy: got %b want 1", rst_busy);
        end
        n_cmp++;
        if (xres_seen !== 2'b00) begin
            n_err++; $display("FAIL reset_seen: got %b want 00", xres_seen);
        end
        resetb = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            step();
            if (e == 22 || e == 23 || e == 31 || e == 32) begin
                exp_out = {(e >= 32), (e >= 23)};
                n_cmp++;
                if (resetb_out !== exp_out) begin
                    n_err++; $display("FAIL startup_out edge %0d: got %b want %b", e, resetb_out, exp_out);
                end
            end
            if (e == 31 || e == 32) begin
                n_cmp++;
                if (rst_busy !== (e < 32)) begin
                    n_err++; $display("FAIL startup_busy edge %0d: got %b want %b", e, rst_busy, (e < 32));
                end
            end
        end
        n_cmp++;
        if (xres_seen !== 2'b11) begin
            n_err++; $display("FAIL startup_seen: got %b want 11", xres_seen);
        end
    endtask

    task automatic test_glitch();
        seen_clr = 1'b1;
        step();
        seen_clr = 1'b0;
        n_cmp++;
        if (xres_seen !== 2'b00) begin
            n_err++; $display("FAIL glitch_clr_seen: got %b want 00", xres_seen);
        end
        xres_in[1] = 1'b0;
        #1;
        n_cmp++;
        if (resetb_out !== 2'b01) begin
            n_err++; $display("FAIL glitch_async: got %b want 01", resetb_out);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (resetb_out !== 2'b01) begin
                n_err++; $display("FAIL glitch_low cycle %0d: got %b want 01", i, resetb_out);
            end
        end
        n_cmp++;
        if (rst_busy !== 1'b1) begin
            n_err++; $display("FAIL glitch_busy: got %b want 1", rst_busy);
        end
        xres_in[1] = 1'b1;
        for (int e = 1; e <= 23; e++) begin
            step();
            if (e == 22 || e == 23) begin
                n_cmp++;
                if (resetb_out !== ((e >= 23) ? 2'b11 : 2'b01)) begin
                    n_err++; $display("FAIL glitch_return edge %0d: got %b want %b", e, resetb_out, (e >= 23) ? 2'b11 : 2'b01);
                end
            end
        end
        n_cmp++;
        if (xres_seen !== 2'b10) begin
            n_err++; $display("FAIL glitch_seen: got %b want 10", xres_seen);
        end
    endtask

    task automatic test_bounce();
        logic [1:0] exp_out;
        xres_in[0] = 1'b0;
        #1;
        n_cmp++;
        if (resetb_out[0] !== 1'b0) begin
            n_err++; $display("FAIL bounce_async0: got %b want 0", resetb_out[0]);
        end
        step();
        for (int i = 0; i < 5; i++) begin
            xres_in[0] = 1'b1;
            step();
            step();
            n_cmp++;
            if (resetb_out !== 2'b00) begin
                n_err++; $display("FAIL bounce_hold pass %0d: got %b want 00", i, resetb_out);
            end
            xres_in[0] = 1'b0;
            step();
            step();
        end
        n_cmp++;
        if (dut.state_q !== ST_HOLD) begin
            n_err++; $display("FAIL bounce_state: got %0d want %0d", dut.state_q, ST_HOLD);
        end
        xres_in[0] = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            step();
            if (e == 22 || e == 23 || e == 31 || e == 32) begin
                exp_out = {(e >= 32), (e >= 23)};
                n_cmp++;
                if (resetb_out !== exp_out) begin
                    n_err++; $display("FAIL bounce_release edge %0d: got %b want %b", e, resetb_out, exp_out);
                end
            end
        end
    endtask

    task automatic test_gap_drop();
        logic [1:0] exp_out;
        xres_in[0] = 1'b0;
        step();
        xres_in[0] = 1'b1;
        for (int e = 1; e <= 26; e++) step();
        n_cmp++;
        if (dut.state_q !== ST_GAP || dut.ptr_q !== 2'd1 || resetb_out !== 2'b01) begin
            n_err++; $display("FAIL gap_entry: got state %0d ptr %0d out %b want state %0d ptr 1 out 01",
                              dut.state_q, dut.ptr_q, resetb_out, ST_GAP);
        end
        xres_in[0] = 1'b0;
        #1;
        n_cmp++;
        if (resetb_out !== 2'b00) begin
            n_err++; $display("FAIL gap_async: got %b want 00", resetb_out);
        end
        step();
        n_cmp++;
        if (dut.ptr_q !== 2'd0 || dut.state_q !== ST_HOLD || rst_busy !== 1'b1) begin
            n_err++; $display("FAIL gap_drop: got ptr %0d state %0d busy %b want ptr 0 state %0d busy 1",
                              dut.ptr_q, dut.state_q, rst_busy, ST_HOLD);
        end
        step();
        xres_in[0] = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            step();
            if (e == 22 || e == 23 || e == 32) begin
                exp_out = {(e >= 32), (e >= 23)};
                n_cmp++;
                if (resetb_out !== exp_out) begin
                    n_err++; $display("FAIL gap_restart edge %0d: got %b want %b", e, resetb_out, exp_out);
                end
            end
        end
    endtask

    task automatic test_simul_drop();
        seen_clr = 1'b1;
        step();
        seen_clr = 1'b0;
        n_cmp++;
        if (xres_seen !== 2'b00) begin
            n_err++; $display("FAIL simul_clr_seen: got %b want 00", xres_seen);
        end
        xres_in  = 2'b00;
        seen_clr = 1'b1;
        #1;
        n_cmp++;
        if (resetb_out !== 2'b00) begin
            n_err++; $display("FAIL simul_async: got %b want 00", resetb_out);
        end
        step();
        seen_clr = 1'b0;
        n_cmp++;
        if (dut.ptr_q !== 2'd0 || rst_busy !== 1'b1) begin
            n_err++; $display("FAIL simul_ptr: got ptr %0d busy %b want ptr 0 busy 1", dut.ptr_q, rst_busy);
        end
        n_cmp++;
        if (xres_seen !== 2'b11) begin
            n_err++; $display("FAIL simul_seen_beats_clr: got %b want 11", xres_seen);
        end
        step();
    endtask

    task automatic test_reset_mid_stretch();
        xres_in = 2'b11;
        for (int e = 1; e <= 10; e++) step();
        n_cmp++;
        if (dut.state_q !== ST_STRETCH || dut.cnt_q !== 5'd4) begin
            n_err++; $display("FAIL stretch_entry: got state %0d cnt %0d want state %0d cnt 4",
                              dut.state_q, dut.cnt_q, ST_STRETCH);
        end
        resetb = 1'b0;
        #1;
        n_cmp++;
        if (resetb_out !== 2'b00 || rst_busy !== 1'b1 || xres_seen !== 2'b00) begin
            n_err++; $display("FAIL midreset_outputs: got out %b busy %b seen %b want 00 1 00",
                              resetb_out, rst_busy, xres_seen);
        end
        n_cmp++;
        if (dut.state_q !== ST_HOLD || dut.ptr_q !== 2'd0 || dut.cnt_q !== 5'd0) begin
            n_err++; $display("FAIL midreset_state: got state %0d ptr %0d cnt %0d want %0d 0 0",
                              dut.state_q, dut.ptr_q, dut.cnt_q, ST_HOLD);
        end
        step();
        resetb = 1'b1;
        for (int e = 1; e <= 23; e++) begin
            step();
            if (e == 22 || e == 23) begin
                n_cmp++;
                if (resetb_out !== ((e >= 23) ? 2'b01 : 2'b00)) begin
                    n_err++; $display("FAIL midreset_release edge %0d: got %b want %b", e, resetb_out, (e >= 23) ? 2'b01 : 2'b00);
                end
            end
        end
    endtask

    task automatic test_sweep4();
        logic [3:0] exp4;
        resetb4 = 1'b0;
        xres4   = 4'b1111;
        step();
        n_cmp++;
        if (out4 !== 4'b0000 || busy4 !== 1'b1) begin
            n_err++; $display("FAIL sweep_reset: got out %b busy %b want 0000 1", out4, busy4);
        end
        resetb4 = 1'b1;
        for (int e = 1; e <= 29; e++) begin
            step();
            if (e >= 22) begin
                exp4 = '0;
                for (int k = 0; k < 4; k++) begin
                    if (e >= 23 + 2 * k) exp4[k] = 1'b1;
                end
                n_cmp++;
                if (out4 !== exp4) begin
                    n_err++; $display("FAIL sweep_out edge %0d: got %b want %b", e, out4, exp4);
                end
            end
            if (e == 28 || e == 29) begin
                n_cmp++;
                if (busy4 !== (e < 29)) begin
                    n_err++; $display("FAIL sweep_busy edge %0d: got %b want %b", e, busy4, (e < 29));
                end
            end
        end
    endtask

    initial begin
        resetb   = 1'b0;
        xres_in  = 2'b11;
        seen_clr = 1'b0;
        resetb4  = 1'b0;
        xres4    = 4'b1111;
        clr4     = 1'b0;
        test_reset();
        test_glitch();
        test_bounce();
        test_gap_drop();
        test_simul_drop();
        test_reset_mid_stretch();
        test_sweep4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
